// File: rtl/freq_meter_pkg.sv
// Shared definitions for the signal frequency meter: FSM state encoding and default
// gate/counter sizing used by both the meter and the clock-divider bench.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } meter_state_t;

    localparam int DEF_GATE_CYCLES = 50_000_000;
    localparam int DEF_CNT_W       = 28;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold gate counter values 0 .. cycles-1.
    function automatic int gate_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous 1-bit input followed by a registered
// rising-edge detector; rise appears SYNC_STAGES+1 clocks after the input rises.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_q_sync = r_sync[SYNC_STAGES-1];
    assign o_rise   = r_rise;

endmodule

// File: rtl/sig_freq_meter.sv
// Counts synchronised rising edges of a slow asynchronous signal over a gate window of
// GATE_CYCLES clocks and publishes the count with a one-cycle valid strobe.
module sig_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig_in,
    input  logic             i_start,
    input  logic             i_cont,
    output logic             o_edge_tick,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_freq_cnt,
    output logic             o_valid,
    output logic             o_overflow
);

    // Gate counter is sized from the window length so a narrow edge counter can still
    // be paired with a long window (that is how saturation becomes reachable).
    localparam int                GATE_W    = gate_width(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    meter_state_t      r_state;
    meter_state_t      w_state_next;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_ovf;
    logic              w_rise;
    logic              w_edge_sat;
    logic [CNT_W-1:0]  w_edge_next;
    logic              w_ovf_next;
    logic              w_arm;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_sig_in),
        .o_q_sync(),
        .o_rise  (w_rise)
    );

    assign o_edge_tick = w_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (i_start | i_cont) w_state_next = ST_MEASURE;
            ST_MEASURE: if (r_gate_cnt == GATE_LAST) w_state_next = ST_DONE;
            ST_DONE:    w_state_next = i_cont ? ST_MEASURE : ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Saturating view of the edge counter including this cycle's tick, so the final
    // window cycle is captured when the result is latched.
    always_comb begin
        w_edge_sat  = (r_edge_cnt == CNT_MAX);
        w_edge_next = r_edge_cnt;
        w_ovf_next  = r_ovf;
        if (w_rise) begin
            if (w_edge_sat) begin
                w_ovf_next = 1'b1;
            end else begin
                w_edge_next = r_edge_cnt + 1'b1;
            end
        end
    end

    assign w_arm = (w_state_next == ST_MEASURE) && (r_state != ST_MEASURE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_arm) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (r_state == ST_MEASURE) begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            r_edge_cnt <= w_edge_next;
            r_ovf      <= w_ovf_next;
        end
    end

    // Outputs are registered from the next state so busy/valid line up with MEASURE/DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_freq_cnt <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_busy  <= (w_state_next == ST_MEASURE);
            o_valid <= (w_state_next == ST_DONE);
            if (w_state_next == ST_DONE) begin
                o_freq_cnt <= w_edge_next;
                o_overflow <= w_ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_sig_freq_meter.sv
// Self-checking bench for sig_freq_meter: two instances (8-bit and 5-bit edge counters)
// share stimulus; window results are predicted from a recorded history of sig_in.
module tb_sig_freq_meter;

    localparam int G    = 100;
    localparam int CW   = 8;
    localparam int CW2  = 5;
    localparam int SS   = 2;
    localparam int MAXC = 20000;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          sigIn  = 1'b0;
    logic          start  = 1'b0;
    logic          cont   = 1'b0;
    logic          tick1, busy1, valid1, ovf1;
    logic [CW-1:0] freq1;
    logic          tick2, busy2, valid2, ovf2;
    logic [CW2-1:0] freq2;

    int checkCount = 0;
    int errorCount = 0;
    int cyc        = 0;
    bit hist[MAXC];
    int sigMode    = 0;
    bit sigLevel   = 1'b0;
    int sigPeriod  = 10;
    int sigPhase   = 0;

    sig_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .i_clk(clk), .i_rst(rst), .i_sig_in(sigIn), .i_start(start), .i_cont(cont),
        .o_edge_tick(tick1), .o_busy(busy1), .o_freq_cnt(freq1), .o_valid(valid1),
        .o_overflow(ovf1)
    );

    sig_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW2), .SYNC_STAGES(SS)) dutNarrow (
        .i_clk(clk), .i_rst(rst), .i_sig_in(sigIn), .i_start(start), .i_cont(cont),
        .o_edge_tick(tick2), .o_busy(busy2), .o_freq_cnt(freq2), .o_valid(valid2),
        .o_overflow(ovf2)
    );

    always #5 clk = ~clk;

    // Record what the synchroniser sees at each rising edge; reset forces the chain to 0.
    always @(posedge clk) begin
        if (cyc < MAXC) hist[cyc] = rst ? 1'b0 : sigIn;
        cyc = cyc + 1;
    end

    // sig_in changes only on falling edges: held level, square wave, or random bits.
    always @(negedge clk) begin
        case (sigMode)
            0: sigIn = sigLevel;
            1: begin
                sigIn    = ((sigPhase % sigPeriod) < (sigPeriod / 2));
                sigPhase = sigPhase + 1;
            end
            default: sigIn = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic int histAt(input int k);
        return (k < 0 || k >= MAXC) ? 0 : int'(hist[k]);
    endfunction

    // A rise sampled at edge k becomes a tick seen at edge k+3; the window started at
    // edge p counts ticks seen at edges p+1 .. p+G.
    function automatic int modelCount(input int p);
        int c = 0;
        for (int k = p - 2; k <= p + G - 3; k++) begin
            if (histAt(k) == 1 && histAt(k - 1) == 0) c++;
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Pulse start for one cycle; p is the index of the edge that samples it.
    task automatic applyStimulus(output int p);
        @(negedge clk);
        p     = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitValid(input int budget, output int m);
        m = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid1 === 1'b1) begin
                m = cyc - 1;
                break;
            end
        end
        if (m < 0) checkOutput("validTimeout", 0, 1);
    endtask

    task automatic checkWindow(input string tag, input int pExp);
        int m;
        int c;
        waitValid(G + 30, m);
        if (m >= 0) begin
            c = modelCount(m - G);
            checkOutput({tag, ".latency"}, m - pExp, G);
            checkOutput({tag, ".freq"}, int'(freq1), c);
            checkOutput({tag, ".ovf"}, int'(ovf1), (c > 255) ? 1 : 0);
            checkOutput({tag, ".freqNarrow"}, int'(freq2), (c > 31) ? 31 : c);
            checkOutput({tag, ".ovfNarrow"}, int'(ovf2), (c > 31) ? 1 : 0);
            checkOutput({tag, ".validNarrow"}, int'(valid2), 1);
            checkOutput({tag, ".busyInDone"}, int'(busy1), 0);
        end
    endtask

    task automatic countValids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid1 === 1'b1) n++;
        end
    endtask

    initial begin
        int p;
        int dummy;
        int nv;
        int m;
        int expTick;

        // Reset state
        repeat (4) @(negedge clk);
        checkOutput("rst.freq", int'(freq1), 0);
        checkOutput("rst.valid", int'(valid1), 0);
        checkOutput("rst.busy", int'(busy1), 0);
        checkOutput("rst.ovf", int'(ovf1), 0);
        checkOutput("rst.tick", int'(tick1), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Period-10 square wave, single window
        sigMode = 1; sigPeriod = 10; sigPhase = 0;
        repeat (3) @(negedge clk);
        applyStimulus(p);
        checkOutput("t1.busy", int'(busy1), 1);
        checkWindow("t1", p);
        checkOutput("t1.ten", int'(freq1), 10);
        @(negedge clk);
        checkOutput("t1.validPulse", int'(valid1), 0);

        // Held low: zero edges, exactly one valid
        sigMode = 0; sigLevel = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(p);
        checkWindow("t2", p);
        checkOutput("t2.zero", int'(freq1), 0);
        countValids(40, nv);
        checkOutput("t2.singleValid", nv, 0);

        // Held high through reset release: no edge counted
        sigLevel = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus(p);
        checkWindow("t2b", p);
        checkOutput("t2b.zero", int'(freq1), 0);

        // Continuous mode, period 4
        sigMode = 1; sigPeriod = 4;
        @(negedge clk);
        p    = cyc;
        cont = 1'b1;
        for (int w = 0; w < 3; w++) begin
            checkWindow("t3", p + w * (G + 1));
            checkOutput("t3.range", int'(freq1 >= 24 && freq1 <= 26), 1);
            if (w == 2) cont = 1'b0;
            @(negedge clk);
            checkOutput("t3.validPulse", int'(valid1), 0);
            checkOutput("t3.rearm", int'(busy1), (w < 2) ? 1 : 0);
        end

        // Toggle every clock: 50 edges, narrow counter saturates
        sigPeriod = 2;
        repeat (3) @(negedge clk);
        applyStimulus(p);
        checkWindow("t4", p);
        checkOutput("t4.sat", int'(freq2), 31);
        checkOutput("t4.ovf", int'(ovf2), 1);

        // Reset in the middle of a window
        sigPeriod = 10;
        applyStimulus(p);
        while (cyc < p + 51) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5.freq", int'(freq1), 0);
        checkOutput("t5.busy", int'(busy1), 0);
        checkOutput("t5.valid", int'(valid1), 0);
        checkOutput("t5.ovfNarrow", int'(ovf2), 0);
        @(negedge clk); rst = 1'b0;
        countValids(150, nv);
        checkOutput("t5.noValid", nv, 0);
        applyStimulus(p);
        checkWindow("t5b", p);
        checkOutput("t5b.ten", int'(freq1), 10);

        // Start pulsed mid-window is ignored
        repeat (4) @(negedge clk);
        applyStimulus(p);
        repeat (30) @(negedge clk);
        applyStimulus(dummy);
        checkWindow("t6", p);
        countValids(G + 20, nv);
        checkOutput("t6.noQueue", nv, 0);

        // edge_tick runs in IDLE, three clocks after each sampled rise
        sigMode = 2;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            m       = cyc - 1;
            expTick = (histAt(m - 2) == 1 && histAt(m - 3) == 0) ? 1 : 0;
            checkOutput("t7.tick", int'(tick1), expTick);
            checkOutput("t7.tickNarrow", int'(tick2), expTick);
        end

        // Randomised windows
        for (int r = 0; r < 8; r++) begin
            sigMode   = $urandom_range(0, 2);
            sigLevel  = 1'($urandom_range(0, 1));
            sigPeriod = $urandom_range(2, 12);
            sigPhase  = $urandom_range(0, 11);
            repeat ($urandom_range(3, 20)) @(negedge clk);
            applyStimulus(p);
            checkWindow("t8", p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
